// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared sizes, key-code type, scan FSM encoding and key-code
//                helper for the keypad matrix scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

  localparam int NROW  = 4;
  localparam int NCOL  = 5;
  localparam int KEY_W = 5;

  typedef logic [KEY_W-1:0] key_code_t;

  // Scan FSM encoding, explicit one-bit width
  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    EVAL   = 1'b1
  } scan_state_e;

  localparam key_code_t NO_KEY = '0;

  // Key at (row, col) is numbered row-major starting at 1 so that 0 stays free
  // for "no key".
  function automatic key_code_t key_code(input logic [1:0] row, input logic [2:0] col);
    return key_code_t'(int'(row) * NCOL + int'(col) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_frame_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_frame_debounce
//  Description : Frame-level debounce of the per-frame key code. A code is
//                reported (nkv update plus one-cycle nkpls) once it has been
//                seen on DEB_CNT consecutive frames and differs from the last
//                reported code.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_frame_debounce
  import key_pkg::*;
#(
  parameter int DEB_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] fc,
  input  logic             eval_en,
  output logic [KEY_W-1:0] nkv,
  output logic             nkpls
);

  localparam logic [3:0] DEB_MAX = 4'(DEB_CNT);

  key_code_t  prev_q, prev_d;
  logic [3:0] cnt_q, cnt_d;
  // The reported code doubles as the "last reported" register, so nkv can
  // never disagree with the value debounce compares against.
  key_code_t  rep_q, rep_d;
  logic       nkpls_q, nkpls_d;

  // Debounce update, only active during the one-cycle EVAL slot
  always_comb begin
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    nkpls_d = 1'b0;
    if (eval_en) begin
      if (fc == prev_q) begin
        cnt_d = (cnt_q >= DEB_MAX) ? DEB_MAX : cnt_q + 4'd1;
      end else begin
        cnt_d  = 4'd1;
        prev_d = fc;
      end
      if ((cnt_d == DEB_MAX) && (fc != rep_q)) begin
        rep_d   = fc;
        nkpls_d = 1'b1;
      end
    end
  end

  // Debounce state registers; cnt starts saturated so idle after reset is quiet
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= NO_KEY;
      cnt_q   <= DEB_MAX;
      rep_q   <= NO_KEY;
      nkpls_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      nkpls_q <= nkpls_d;
    end
  end

  assign nkv   = rep_q;
  assign nkpls = nkpls_q;

endmodule
`default_nettype wire

// File: rtl/key_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module      : key_matrix_scan
//  Description : 4x5 passive key matrix scanner. Drives one column low at a
//                time, samples synchronized rows, resolves each frame to a
//                single key code and hands it to the frame debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_matrix_scan
  import key_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEB_CNT  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NROW-1:0]  krow,
  output logic [NCOL-1:0]  kcol,
  output logic             nkpls,
  output logic [KEY_W-1:0] nkv
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int               COL_W    = 3;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NCOL - 1);

  logic [NROW-1:0]  krow_meta_q;
  logic [NROW-1:0]  krow_sync_q;

  scan_state_e      state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [DIV_W-1:0] div_q, div_d;
  // Frame accumulator: hit count saturating at 2, plus the code of the first hit
  logic [1:0]       hits_q, hits_d;
  key_code_t        code_q, code_d;

  logic [1:0]       row_hits;
  logic [1:0]       row_idx;
  logic [2:0]       hits_sum;
  logic             eval_en;
  key_code_t        fc;

  // Two-flop synchronizer for the asynchronous, active-low rows
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      krow_meta_q <= '1;
      krow_sync_q <= '1;
    end else begin
      krow_meta_q <= krow;
      krow_sync_q <= krow_meta_q;
    end
  end

  // Count low rows in the current column (saturating at 2) and locate one
  always_comb begin
    row_hits = 2'd0;
    row_idx  = 2'd0;
    for (int r = NROW - 1; r >= 0; r--) begin
      if (!krow_sync_q[r]) begin
        row_idx = 2'(r);
        if (row_hits != 2'd2) begin
          row_hits = row_hits + 2'd1;
        end
      end
    end
  end

  assign hits_sum = {1'b0, hits_q} + {1'b0, row_hits};

  // Scan sequencing: divider per column, column walk, then one EVAL cycle
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    div_d   = div_q;
    hits_d  = hits_q;
    code_d  = code_q;
    eval_en = 1'b0;
    case (state_q)
      SETTLE: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          hits_d = (hits_sum > 3'd2) ? 2'd2 : hits_sum[1:0];
          if ((hits_q == 2'd0) && (row_hits == 2'd1)) begin
            code_d = key_code(row_idx, col_q);
          end
          if (col_q == COL_LAST) begin
            state_d = EVAL;
          end else begin
            col_d = col_q + 3'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      EVAL: begin
        eval_en = 1'b1;
        state_d = SETTLE;
        col_d   = '0;
        hits_d  = 2'd0;
        code_d  = NO_KEY;
      end
      default: begin
        state_d = SETTLE;
      end
    endcase
  end

  // Scan FSM, divider and frame accumulator registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SETTLE;
      col_q   <= '0;
      div_q   <= '0;
      hits_q  <= 2'd0;
      code_q  <= NO_KEY;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      div_q   <= div_d;
      hits_q  <= hits_d;
      code_q  <= code_d;
    end
  end

  // Exactly one hit in the frame yields its code; none or several yield 0
  assign fc = (hits_q == 2'd1) ? code_q : NO_KEY;

  // Column drive decoded from registered state, so it only moves on register updates
  always_comb begin
    kcol = '1;
    for (int c = 0; c < NCOL; c++) begin
      if ((state_q == SETTLE) && (col_q == COL_W'(c))) begin
        kcol[c] = 1'b0;
      end
    end
  end

  key_frame_debounce #(
    .DEB_CNT (DEB_CNT)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .fc      (fc),
    .eval_en (eval_en),
    .nkv     (nkv),
    .nkpls   (nkpls)
  );

endmodule
`default_nettype wire
